// File: rtl/port_display_pacer_pkg.sv
// Shared types and board constants for the port display pacer.
package port_display_pacer_pkg;

    typedef enum logic {IDLE, SHOW} pacer_state_t;

    // Motherboard system clock; one second of display time at this rate.
    localparam int unsigned MB_CLK_HZ = 33_000_000;

endpackage

// File: rtl/port_display_pacer_if.sv
// CPU output-port side of the pacer: write strobe/data in, display and status out.
interface port_display_pacer_if;

    logic       wr;
    logic [7:0] wd;
    logic       full;
    logic       ovf;
    logic [7:0] hex;
    logic       showing;

    modport master (output wr, wd, input full, ovf, hex, showing);
    modport slave  (input wr, wd, output full, ovf, hex, showing);

endinterface

// File: rtl/port_display_pacer_fifo.sv
// Small show-ahead FIFO holding CPU port bytes until the display is free.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [AW:0]      wr_ptr_nxt, rd_ptr_nxt;
    logic [WIDTH-1:0] mem [DEPTH];

    // Next pointer values; the extra MSB separates full from empty.
    always_comb begin
        wr_ptr_nxt = push ? wr_ptr + 1'b1 : wr_ptr;
        rd_ptr_nxt = pop  ? rd_ptr + 1'b1 : rd_ptr;
    end

    // Pointer registers and registered full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
        end
    end

    // Storage; a push into a full FIFO with a pop overwrites the slot being read out.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/port_display_pacer.sv
// Paces CPU output-port bytes onto the two hex LED digits, one byte per hold window.
//
// state | meaning
// IDLE  | no hold window running; HEX keeps the last byte shown
// SHOW  | a byte is on HEX and its hold window is counting
module port_display_pacer
    import port_display_pacer_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = MB_CLK_HZ
) (
    input  logic clk_33,
    input  logic rst,
    port_display_pacer_if.slave port
);

    localparam int              CW        = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_CYCLES - 1);

    pacer_state_t  state;
    logic [CW-1:0] hold_cnt;
    logic [7:0]    hex_q;
    logic          showing_q;
    logic          ovf_q;
    logic          empty_q;
    logic          fifo_empty, fifo_full;
    logic [7:0]    head;
    logic          pop, push;

    // Pop at the start of a window; a full FIFO still accepts a write on a pop cycle.
    always_comb begin
        pop = 1'b0;
        if (state == IDLE) pop = !empty_q;
        else               pop = (hold_cnt == HOLD_LAST) && !fifo_empty;
        push = port.wr && (!fifo_full || pop);
    end

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk_33),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (port.wd),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Display FSM. IDLE looks at a one-cycle-late empty flag so a fresh byte
    // lands on HEX two edges after its write; SHOW uses the live flag so a byte
    // written late in a window still follows it without a gap.
    always_ff @(posedge clk_33) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            hex_q     <= 8'h00;
            showing_q <= 1'b0;
            ovf_q     <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            empty_q <= fifo_empty;
            if (port.wr && !push) ovf_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (pop) begin
                        hex_q     <= head;
                        hold_cnt  <= '0;
                        showing_q <= 1'b1;
                        state     <= SHOW;
                    end
                end
                SHOW: begin
                    if (hold_cnt == HOLD_LAST) begin
                        if (pop) begin
                            hex_q    <= head;
                            hold_cnt <= '0;
                        end else begin
                            showing_q <= 1'b0;
                            state     <= IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign port.full    = fifo_full;
    assign port.ovf     = ovf_q;
    assign port.hex     = hex_q;
    assign port.showing = showing_q;

endmodule
